enemy_bomb: RTL and testbench

ENEMY_BOMB -- requirements
Module: enemy_bomb

---
 rtl/enemy_bomb.sv | 190 +++++++++++++++++++
 tb/tb_enemy_bomb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_bomb.sv
// Falling bomb dropped by the enemy plane: frame-tick driven fall with stepped
// gravity, character/ground collision, three-frame explosion and a cooldown.
module enemy_bomb #(
    parameter logic [9:0] GROUND_Y = 10'd440,
    parameter logic [9:0] BOMB_SZ  = 10'd8,
    parameter logic [9:0] EXP_SZ   = 10'd16,
    parameter logic [9:0] CHAR_W   = 10'd26,
    parameter logic [9:0] CHAR_H   = 10'd38,
    parameter logic [5:0] COOLDOWN = 6'd30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        launch,
    input  logic [9:0]  start_x,
    input  logic [9:0]  start_y,
    input  logic [9:0]  char_x,
    input  logic [9:0]  char_y,
    output logic        is_bomb,
    output logic [11:0] bomb_addr,
    output logic        hit_char,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_FALL, S_EXPLODE, S_COOL} state_t;

    localparam logic [10:0] EXP_OFF = 11'd4;

    state_t      state_q, state_d;
    logic [9:0]  bx_q, bx_d, by_q, by_d;
    logic [2:0]  vy_q, vy_d;
    logic [1:0]  fall_cnt_q, fall_cnt_d;
    logic [4:0]  exp_cnt_q, exp_cnt_d;
    logic [5:0]  cool_cnt_q, cool_cnt_d;
    logic        hit_q, hit_d;
    logic [1:0]  sync_q;
    logic        edge_q;

    logic        tick;
    logic        overlap;
    logic        ground;
    logic [10:0] bx_w, by_w, cx_w, cy_w;
    logic [10:0] fdx, fdy, edx, edy;

    assign tick = sync_q[1] & ~edge_q;

    // Widened to 11 bits so box sums near the screen edge do not wrap.
    assign bx_w    = {1'b0, bx_q};
    assign by_w    = {1'b0, by_q};
    assign cx_w    = {1'b0, char_x};
    assign cy_w    = {1'b0, char_y};
    assign overlap = (bx_w < cx_w + {1'b0, CHAR_W}) && (cx_w < bx_w + {1'b0, BOMB_SZ}) &&
                     (by_w < cy_w + {1'b0, CHAR_H}) && (cy_w < by_w + {1'b0, BOMB_SZ});
    assign ground  = (by_w + {8'd0, vy_q} + {1'b0, BOMB_SZ}) >= {1'b0, GROUND_Y};

    assign fdx = {1'b0, DrawX} - bx_w;
    assign fdy = {1'b0, DrawY} - by_w;
    assign edx = {1'b0, DrawX} + EXP_OFF - bx_w;
    assign edy = {1'b0, DrawY} + EXP_OFF - by_w;

    assign hit_char = hit_q;
    assign busy     = (state_q != S_IDLE);

    // State, position, counters and frame strobe synchroniser.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            bx_q       <= 10'd0;
            by_q       <= 10'd0;
            vy_q       <= 3'd0;
            fall_cnt_q <= 2'd0;
            exp_cnt_q  <= 5'd0;
            cool_cnt_q <= 6'd0;
            hit_q      <= 1'b0;
            sync_q     <= 2'b00;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            vy_q       <= vy_d;
            fall_cnt_q <= fall_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            hit_q      <= hit_d;
            sync_q     <= {sync_q[0], frame_clk};
            edge_q     <= sync_q[1];
        end
    end

    // Next-state: launch latch, fall physics, collision, explosion and cooldown timers.
    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        vy_d       = vy_q;
        fall_cnt_d = fall_cnt_q;
        exp_cnt_d  = exp_cnt_q;
        cool_cnt_d = cool_cnt_q;
        hit_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    bx_d       = start_x;
                    by_d       = start_y + 10'd19;
                    vy_d       = 3'd0;
                    fall_cnt_d = 2'd0;
                    state_d    = S_FALL;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_FALL: begin
                if (!tick) begin
                    state_d = S_FALL;
                end else if (overlap) begin
                    hit_d     = 1'b1;
                    exp_cnt_d = 5'd0;
                    state_d   = S_EXPLODE;
                end else if (ground) begin
                    by_d      = GROUND_Y - BOMB_SZ;
                    exp_cnt_d = 5'd0;
                    state_d   = S_EXPLODE;
                end else begin
                    by_d       = by_q + {7'd0, vy_q};
                    fall_cnt_d = fall_cnt_q + 2'd1;
                    // Gravity steps up on every fourth tick, capped at 4 px/tick.
                    if (fall_cnt_q == 2'd3 && vy_q < 3'd4) begin
                        vy_d = vy_q + 3'd1;
                    end else begin
                        vy_d = vy_q;
                    end
                end
            end
            S_EXPLODE: begin
                if (!tick) begin
                    state_d = S_EXPLODE;
                end else if (exp_cnt_q == 5'd23) begin
                    cool_cnt_d = 6'd0;
                    state_d    = S_COOL;
                end else begin
                    exp_cnt_d = exp_cnt_q + 5'd1;
                end
            end
            S_COOL: begin
                if (!tick) begin
                    state_d = S_COOL;
                end else if (cool_cnt_q == COOLDOWN - 6'd1) begin
                    state_d = S_IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sprite hit test and ROM address for the current pixel.
    always_comb begin
        is_bomb   = 1'b0;
        bomb_addr = 12'd0;
        case (state_q)
            S_FALL: begin
                if (fdx < {1'b0, BOMB_SZ} && fdy < {1'b0, BOMB_SZ}) begin
                    is_bomb   = 1'b1;
                    bomb_addr = {6'd0, fdy[2:0], fdx[2:0]};
                end else begin
                    is_bomb   = 1'b0;
                end
            end
            S_EXPLODE: begin
                if (edx < {1'b0, EXP_SZ} && edy < {1'b0, EXP_SZ}) begin
                    is_bomb   = 1'b1;
                    bomb_addr = 12'd64 + {2'b00, exp_cnt_q[4:3], 8'd0} + {4'd0, edy[3:0], edx[3:0]};
                end else begin
                    is_bomb   = 1'b0;
                end
            end
            default: begin
                is_bomb   = 1'b0;
                bomb_addr = 12'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_enemy_bomb.sv
// Randomised bench for enemy_bomb against a per-frame behavioural model of the drop.
module tb_enemy_bomb;

    logic        Clk, Reset, frame_clk, launch;
    logic [9:0]  DrawX, DrawY, start_x, start_y, char_x, char_y;
    logic        is_bomb, hit_char, busy;
    logic [11:0] bomb_addr;

    localparam int M_IDLE = 0, M_FALL = 1, M_EXP = 2, M_COOL = 3;

    int n_cmp = 0, n_bad = 0;
    int hit_seen = 0;
    int m_mode = M_IDLE, m_bx = 0, m_by = 0, m_t = 0, m_cx = 0, m_cy = 0;
    int m_hits = 0, m_drops = 0;
    bit m_held = 0;

    enemy_bomb dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .launch(launch),
        .start_x(start_x), .start_y(start_y), .char_x(char_x), .char_y(char_y),
        .is_bomb(is_bomb), .bomb_addr(bomb_addr), .hit_char(hit_char), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Counts every hit pulse the design emits.
    always @(posedge Clk) begin
        if (hit_char === 1'b1) hit_seen <= hit_seen + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_start();
        m_mode = M_FALL;
        m_bx   = int'(start_x);
        m_by   = (int'(start_y) + 19) % 1024;
        m_t    = 0;
        m_drops++;
    endfunction

    // One frame tick of the drop as described in prose: gravity min(t/4,4).
    function automatic void model_tick();
        int vy;
        m_cx = int'(char_x);
        m_cy = int'(char_y);
        case (m_mode)
            M_FALL: begin
                vy = (m_t / 4 > 4) ? 4 : m_t / 4;
                if (m_bx < m_cx + 26 && m_cx < m_bx + 8 && m_by < m_cy + 38 && m_cy < m_by + 8) begin
                    m_hits++;
                    m_mode = M_EXP;
                    m_t = 0;
                end else if (m_by + vy + 8 >= 440) begin
                    m_by = 432;
                    m_mode = M_EXP;
                    m_t = 0;
                end else begin
                    m_by += vy;
                    m_t++;
                end
            end
            M_EXP: begin
                m_t++;
                if (m_t == 24) begin m_mode = M_COOL; m_t = 0; end
            end
            M_COOL: begin
                m_t++;
                if (m_t == 30) m_mode = M_IDLE;
            end
            default: ;
        endcase
    endfunction

    task automatic probe(input int x, input int y);
        int bx0, by0, sz, base, dx, dy, e_in, e_addr;
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        e_in = 0; e_addr = 0; sz = 0; bx0 = 0; by0 = 0; base = 0;
        if (m_mode == M_FALL) begin
            bx0 = m_bx; by0 = m_by; sz = 8;
        end else if (m_mode == M_EXP) begin
            bx0 = m_bx - 4; by0 = m_by - 4; sz = 16; base = 64 + 256 * (m_t / 8);
        end
        dx = x - bx0;
        dy = y - by0;
        if (sz > 0 && dx >= 0 && dx < sz && dy >= 0 && dy < sz) begin
            e_in = 1;
            e_addr = base + dy * sz + dx;
        end
        check_val("is_bomb", int'(is_bomb), e_in);
        check_val("bomb_addr", int'(bomb_addr), e_addr);
    endtask

    task automatic check_frame();
        int bx0, by0, sz;
        check_val("busy", int'(busy), int'(m_mode != M_IDLE));
        check_val("hit_count", hit_seen, m_hits);
        check_val("hit_idle", int'(hit_char), 0);
        if (m_mode == M_FALL || m_mode == M_EXP) begin
            sz  = (m_mode == M_FALL) ? 8 : 16;
            bx0 = (m_mode == M_FALL) ? m_bx : m_bx - 4;
            by0 = (m_mode == M_FALL) ? m_by : m_by - 4;
            if (by0 + sz <= 1023) begin
                probe(bx0 + int'($urandom_range(0, sz - 1)), by0 + int'($urandom_range(0, sz - 1)));
                if (bx0 + sz <= 1023) probe(bx0 + sz, by0);
                if (by0 > 0) probe(bx0, by0 - 1);
            end
        end else begin
            probe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat (8) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (8) @(negedge Clk);
        model_tick();
        if (m_mode == M_IDLE && m_held) model_start();
        check_frame();
    endtask

    task automatic launch_once();
        launch = 1'b1;
        @(negedge Clk);
        launch = 1'b0;
        if (m_mode == M_IDLE) model_start();
        check_val("busy_after_launch", int'(busy), int'(m_mode != M_IDLE));
    endtask

    task automatic run_drop(input int sx, input int sy, input int cx, input int cy, input int probe_at);
        int n;
        start_x = 10'(sx); start_y = 10'(sy);
        char_x  = 10'(cx); char_y  = 10'(cy);
        launch_once();
        n = 0;
        while (m_mode != M_IDLE && n < 400) begin
            frame();
            n++;
            if (n == probe_at) probe(303, 71);
        end
        if (n >= 400) check_val("drop_timeout", n, 0);
    endtask

    initial begin
        int n, sx;
        Reset = 1'b1; frame_clk = 1'b0; launch = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        start_x = 10'd0; start_y = 10'd0; char_x = 10'd0; char_y = 10'd0;
        repeat (3) @(negedge Clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_hit", int'(hit_char), 0);
        probe(0, 19);
        Reset = 1'b0;
        @(negedge Clk);

        run_drop(300, 50, 0, 0, 1);          // ground landing, pixel (303,71) addr 19
        run_drop(300, 50, 296, 100, -1);     // direct hit
        run_drop(300, 50, 296, 425, -1);     // hit near ground
        run_drop(300, 50, 296, 60, 17);      // immediate hit, explode frame 2 addr 679
        run_drop(300, 1000, 0, 0, -1);       // no wrap near 1023

        // Launch held high throughout: relatch only once back in IDLE.
        start_x = 10'd300; start_y = 10'd50; char_x = 10'd0; char_y = 10'd0;
        launch = 1'b1; m_held = 1'b1; m_drops = 0;
        model_start();
        n = 0;
        while (m_drops < 2 && n < 400) begin
            frame();
            n++;
            if (n == 5) start_x = 10'd500;
        end
        if (n >= 400) check_val("held_timeout", n, 0);
        launch = 1'b0; m_held = 1'b0;
        n = 0;
        while (m_mode != M_IDLE && n < 400) begin frame(); n++; end
        if (n >= 400) check_val("held_drain_timeout", n, 0);

        // Asynchronous reset in the middle of a fall.
        start_x = 10'd300; start_y = 10'd50; char_x = 10'd0; char_y = 10'd0;
        launch_once();
        repeat (10) frame();
        Reset = 1'b1;
        m_mode = M_IDLE;
        probe(m_bx + 1, m_by + 1);
        check_val("async_busy", int'(busy), 0);
        check_val("async_hit", int'(hit_char), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_drop(300, 50, 0, 0, -1);

        for (int d = 0; d < 5; d++) begin
            sx = int'($urandom_range(40, 1000));
            if ($urandom_range(0, 1) == 1)
                run_drop(sx, int'($urandom_range(0, 300)), sx - int'($urandom_range(0, 30)),
                         int'($urandom_range(60, 430)), -1);
            else
                run_drop(sx, int'($urandom_range(0, 300)), int'($urandom_range(0, 600)),
                         int'($urandom_range(0, 440)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
